// File: rtl/cdb_hub_if.sv
// Producer-side handshake and broadcast-lane bundle of the common data bus hub.
// The slave modport is the hub; the master modport is the producer/consumer side.
interface cdb_hub_if #(
    parameter int N_SRC      = 2,
    parameter int N_LANE     = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int RoB_WIDTH  = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int SRC_W      = $clog2(N_SRC),
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
);
    logic [N_SRC-1:0]             src_valid;
    logic [N_SRC-1:0]             src_ready;
    logic [N_SRC*RoB_WIDTH-1:0]   src_rob_index;
    logic [N_SRC*32-1:0]          src_value;
    logic [N_SRC*ADDR_WIDTH-1:0]  src_next_pc;

    logic [N_LANE-1:0]            cdb_en;
    logic [N_LANE*RoB_WIDTH-1:0]  cdb_rob_index;
    logic [N_LANE*32-1:0]         cdb_value;
    logic [N_LANE*ADDR_WIDTH-1:0] cdb_next_pc;
    logic [N_LANE*SRC_W-1:0]      cdb_src;
    logic [N_SRC*CNT_W-1:0]       fifo_count;

    modport master (
        output src_valid, src_rob_index, src_value, src_next_pc,
        input  src_ready, cdb_en, cdb_rob_index, cdb_value, cdb_next_pc, cdb_src, fifo_count
    );

    modport slave (
        input  src_valid, src_rob_index, src_value, src_next_pc,
        output src_ready, cdb_en, cdb_rob_index, cdb_value, cdb_next_pc, cdb_src, fifo_count
    );
endinterface

// File: rtl/cdb_hub.sv
// Buffered common data bus: one FIFO per producer, round-robin grant of up to
// N_LANE heads per cycle onto registered broadcast lanes, with stall and flush.
module cdb_hub #(
    parameter int N_SRC      = 2,
    parameter int N_LANE     = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int RoB_WIDTH  = 8,
    parameter int ADDR_WIDTH = 32,
    parameter int SRC_W      = $clog2(N_SRC)
) (
    input  logic     clk_in,
    input  logic     rst_in,
    input  logic     rdy_in,
    input  logic     clear_in,
    cdb_hub_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [RoB_WIDTH-1:0]  rob_index;
        logic [31:0]           value;
        logic [ADDR_WIDTH-1:0] next_pc;
    } result_t;

    result_t          mem      [N_SRC][FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr   [N_SRC];
    logic [PTR_W-1:0] rd_ptr   [N_SRC];
    logic [CNT_W-1:0] count    [N_SRC];
    logic [SRC_W-1:0] rr_ptr;

    result_t          in_res   [N_SRC];
    logic [N_SRC-1:0] ready;
    logic [N_SRC-1:0] push;
    logic [N_SRC-1:0] grant;

    logic [N_LANE-1:0] gnt_vld;
    logic [SRC_W-1:0]  gnt_src [N_LANE];
    logic [SRC_W-1:0]  rr_next;

    logic [N_LANE-1:0] lane_en_q;
    result_t           lane_res   [N_LANE];
    logic [SRC_W-1:0]  lane_src_q [N_LANE];

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        assign in_res[i] = '{rob_index: bus.src_rob_index[i*RoB_WIDTH +: RoB_WIDTH],
                             value:     bus.src_value[i*32 +: 32],
                             next_pc:   bus.src_next_pc[i*ADDR_WIDTH +: ADDR_WIDTH]};
        // Ready looks only at the registered count: a same-cycle pop never frees the slot.
        assign ready[i] = !rst_in && rdy_in && !clear_in && (count[i] < CNT_W'(FIFO_DEPTH));
        assign push[i]  = bus.src_valid[i] && ready[i];
        assign bus.fifo_count[i*CNT_W +: CNT_W] = count[i];
    end

    assign bus.src_ready = ready;
    assign bus.cdb_en    = lane_en_q;

    for (genvar k = 0; k < N_LANE; k++) begin : g_lane
        assign bus.cdb_rob_index[k*RoB_WIDTH +: RoB_WIDTH]   = lane_res[k].rob_index;
        assign bus.cdb_value[k*32 +: 32]                     = lane_res[k].value;
        assign bus.cdb_next_pc[k*ADDR_WIDTH +: ADDR_WIDTH]   = lane_res[k].next_pc;
        assign bus.cdb_src[k*SRC_W +: SRC_W]                 = lane_src_q[k];
    end

    // Each lane takes the first not-yet-granted non-empty source in scan order from rr_ptr,
    // so lane k always carries the k-th grant and no source is granted twice.
    always_comb begin : p_arb
        logic [N_SRC-1:0] taken;
        logic             found;
        logic [SRC_W-1:0] s;
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        taken   = '0;
        found   = 1'b0;
        s       = '0;
        gnt_vld = '0;
        rr_next = rr_ptr;
        for (int k = 0; k < N_LANE; k++) begin
            found      = 1'b0;
            gnt_src[k] = '0;
            for (int j = 0; j < N_SRC; j++) begin
                s = SRC_W'((int'(rr_ptr) + j) % N_SRC);
                if (!found && count[s] != '0 && !taken[s]) begin
                    found      = 1'b1;
                    taken[s]   = 1'b1;
                    gnt_vld[k] = 1'b1;
                    gnt_src[k] = s;
                    rr_next    = (s == SRC_W'(N_SRC - 1)) ? '0 : s + 1'b1;
                end
            end
        end
        grant = taken;
    end

    // NOTE: entry storage has no reset; only pointers and counts define which entries are live.
    always_ff @(posedge clk_in) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= in_res[i];
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < N_SRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            for (int k = 0; k < N_LANE; k++) begin
                lane_res[k]   <= '0;
                lane_src_q[k] <= '0;
            end
            lane_en_q <= '0;
            rr_ptr    <= '0;
        end else if (clear_in) begin
            // Flush drops every buffered entry but keeps the fairness position and lane data.
            for (int i = 0; i < N_SRC; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            lane_en_q <= '0;
        end else if (rdy_in) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (push[i])  wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (grant[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
                count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(grant[i]);
            end
            for (int k = 0; k < N_LANE; k++) begin
                if (gnt_vld[k]) begin
                    lane_res[k]   <= mem[gnt_src[k]][rd_ptr[gnt_src[k]]];
                    lane_src_q[k] <= gnt_src[k];
                end
            end
            lane_en_q <= gnt_vld;
            rr_ptr    <= rr_next;
        end
    end
endmodule

// File: tb/tb_cdb_hub.sv
// Bench for cdb_hub: one-lane and two-lane hubs share stimulus and are checked
// every cycle against a queue-based reference, plus hand-computed expectations.
module tb_cdb_hub;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0]  rob;
        logic [31:0] val;
        logic [31:0] pc;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        clr = 1'b0;
    logic [1:0]  valid = '0;
    logic [7:0]  rob [2] = '{default: '0};
    logic [31:0] val [2] = '{default: '0};
    logic [31:0] pc  [2] = '{default: '0};

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    cdb_hub_if #(.N_SRC(2), .N_LANE(1), .FIFO_DEPTH(DEPTH)) bus1 ();
    cdb_hub_if #(.N_SRC(2), .N_LANE(2), .FIFO_DEPTH(DEPTH)) bus2 ();

    assign bus1.src_valid     = valid;
    assign bus1.src_rob_index = {rob[1], rob[0]};
    assign bus1.src_value     = {val[1], val[0]};
    assign bus1.src_next_pc   = {pc[1], pc[0]};
    assign bus2.src_valid     = valid;
    assign bus2.src_rob_index = {rob[1], rob[0]};
    assign bus2.src_value     = {val[1], val[0]};
    assign bus2.src_next_pc   = {pc[1], pc[0]};

    cdb_hub #(.N_SRC(2), .N_LANE(1), .FIFO_DEPTH(DEPTH)) u_dut1 (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear_in(clr), .bus(bus1.slave));
    cdb_hub #(.N_SRC(2), .N_LANE(2), .FIFO_DEPTH(DEPTH)) u_dut2 (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear_in(clr), .bus(bus2.slave));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: each hub is a pair of queues plus a fairness pointer; index d = lanes-1.
    ent_t       mq      [2][2][$];
    int         rr      [2] = '{default: 0};
    logic [1:0] exp_en  [2] = '{default: '0};
    ent_t       exp_ln  [2][2] = '{default: '0};
    int         exp_src [2][2] = '{default: 0};
    bit         m_acc   [2];
    int         m_n, m_last, m_s;

    always @(posedge clk or posedge rst) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                mq[d][0].delete();
                mq[d][1].delete();
                exp_en[d] = '0;
                rr[d] = 0;
                for (int k = 0; k < 2; k++) begin
                    exp_ln[d][k]  = '0;
                    exp_src[d][k] = 0;
                end
            end else if (clr) begin
                mq[d][0].delete();
                mq[d][1].delete();
                exp_en[d] = '0;
            end else if (rdy) begin
                for (int s = 0; s < 2; s++) m_acc[s] = valid[s] && (mq[d][s].size() < DEPTH);
                m_n = 0;
                m_last = -1;
                exp_en[d] = '0;
                for (int j = 0; j < 2; j++) begin
                    m_s = (rr[d] + j) % 2;
                    if (mq[d][m_s].size() > 0 && m_n < d + 1) begin
                        exp_ln[d][m_n]  = mq[d][m_s].pop_front();
                        exp_src[d][m_n] = m_s;
                        exp_en[d][m_n]  = 1'b1;
                        m_n++;
                        m_last = m_s;
                    end
                end
                if (m_last >= 0) rr[d] = (m_last + 1) % 2;
                for (int s = 0; s < 2; s++)
                    if (m_acc[s]) mq[d][s].push_back('{rob: rob[s], val: val[s], pc: pc[s]});
            end
        end
    end

    logic [1:0] a_rdy;
    logic [2:0] a_cnt [2];
    logic [1:0] a_en;
    ent_t       a_ln  [2];
    int         a_src [2];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (d == 0) begin
                a_rdy    = bus1.src_ready;
                a_cnt[0] = bus1.fifo_count[2:0];
                a_cnt[1] = bus1.fifo_count[5:3];
                a_en     = {1'b0, bus1.cdb_en};
                a_ln[0]  = '{rob: bus1.cdb_rob_index, val: bus1.cdb_value, pc: bus1.cdb_next_pc};
                a_src[0] = int'(bus1.cdb_src);
                a_ln[1]  = '0;
                a_src[1] = 0;
            end else begin
                a_rdy    = bus2.src_ready;
                a_cnt[0] = bus2.fifo_count[2:0];
                a_cnt[1] = bus2.fifo_count[5:3];
                a_en     = bus2.cdb_en;
                a_ln[0]  = '{rob: bus2.cdb_rob_index[7:0], val: bus2.cdb_value[31:0], pc: bus2.cdb_next_pc[31:0]};
                a_ln[1]  = '{rob: bus2.cdb_rob_index[15:8], val: bus2.cdb_value[63:32], pc: bus2.cdb_next_pc[63:32]};
                a_src[0] = int'(bus2.cdb_src[0]);
                a_src[1] = int'(bus2.cdb_src[1]);
            end
            for (int s = 0; s < 2; s++) begin
                check($sformatf("ready l%0d s%0d", d + 1, s), 64'(a_rdy[s]),
                      64'(!rst && rdy && !clr && (mq[d][s].size() < DEPTH)));
                check($sformatf("count l%0d s%0d", d + 1, s), 64'(a_cnt[s]), 64'(mq[d][s].size()));
            end
            check($sformatf("cdb_en l%0d", d + 1), 64'(a_en), 64'(exp_en[d]));
            for (int k = 0; k <= d; k++) begin
                check($sformatf("rob l%0d k%0d", d + 1, k), 64'(a_ln[k].rob), 64'(exp_ln[d][k].rob));
                check($sformatf("value l%0d k%0d", d + 1, k), 64'(a_ln[k].val), 64'(exp_ln[d][k].val));
                check($sformatf("next_pc l%0d k%0d", d + 1, k), 64'(a_ln[k].pc), 64'(exp_ln[d][k].pc));
                check($sformatf("src l%0d k%0d", d + 1, k), 64'(a_src[k]), 64'(exp_src[d][k]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int s, input logic [7:0] r, input logic [31:0] v, input logic [31:0] p);
        rob[s] = r;
        val[s] = v;
        pc[s]  = p;
    endtask

    int seq_src [6] = '{0, 1, 0, 1, 0, 1};
    int seq_rob [6] = '{1, 11, 2, 12, 3, 13};

    initial begin
        #1;
        check("reset ready", 64'(bus1.src_ready), 64'd0);
        check("reset en", 64'(bus1.cdb_en), 64'd0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("release ready", 64'(bus1.src_ready), 64'h3);

        // Single-source latency: push at E0, visible for exactly one cycle after E1.
        set_src(0, 8'd5, 32'hDEADBEEF, 32'h100);
        valid = 2'b01;
        step();
        valid = 2'b00;
        step();
        check("lat en", 64'(bus1.cdb_en), 64'd1);
        check("lat rob", 64'(bus1.cdb_rob_index), 64'd5);
        check("lat value", 64'(bus1.cdb_value), 64'hDEADBEEF);
        check("lat pc", 64'(bus1.cdb_next_pc), 64'h100);
        check("lat src", 64'(bus1.cdb_src), 64'd0);
        step();
        check("lat en drop", 64'(bus1.cdb_en), 64'd0);

        // Asynchronous reset mid-cycle with three entries queued in the one-lane hub.
        valid = 2'b11;
        set_src(0, 8'd21, 32'h21, 32'h2100);
        set_src(1, 8'd31, 32'h31, 32'h3100);
        step();
        set_src(0, 8'd22, 32'h22, 32'h2200);
        set_src(1, 8'd32, 32'h32, 32'h3200);
        step();
        valid = 2'b00;
        #2 rst = 1'b1;
        #1;
        check("arst en", 64'(bus1.cdb_en), 64'd0);
        check("arst rob", 64'(bus1.cdb_rob_index), 64'd0);
        check("arst value", 64'(bus1.cdb_value), 64'd0);
        check("arst pc", 64'(bus1.cdb_next_pc), 64'd0);
        check("arst count", 64'(bus1.fifo_count), 64'd0);
        check("arst ready", 64'(bus1.src_ready), 64'd0);
        step();
        rst = 1'b0;
        #1;
        check("arst release ready", 64'(bus1.src_ready), 64'h3);

        // Round-robin from rr_ptr=0: three back-to-back pushes per source.
        for (int c = 0; c < 7; c++) begin
            valid = (c < 3) ? 2'b11 : 2'b00;
            set_src(0, 8'(1 + c),  32'hA000 + 32'(c), 32'h1000 + 32'(4 * c));
            set_src(1, 8'(11 + c), 32'hB000 + 32'(c), 32'h2000 + 32'(4 * c));
            step();
            if (c >= 1) begin
                check($sformatf("rr1 en %0d", c), 64'(bus1.cdb_en), 64'd1);
                check($sformatf("rr1 src %0d", c), 64'(bus1.cdb_src), 64'(seq_src[c-1]));
                check($sformatf("rr1 rob %0d", c), 64'(bus1.cdb_rob_index), 64'(seq_rob[c-1]));
            end
            if (c >= 1 && c <= 3) begin
                check($sformatf("rr2 en %0d", c), 64'(bus2.cdb_en), 64'h3);
                check($sformatf("rr2 rob %0d", c), 64'(bus2.cdb_rob_index), 64'({8'(10 + c), 8'(c)}));
                check($sformatf("rr2 src %0d", c), 64'(bus2.cdb_src), 64'h2);
            end
            if (c == 4) check("rr2 idle", 64'(bus2.cdb_en), 64'd0);
        end

        // Full FIFO and back-pressure: both sources stream, the one-lane hub fills up.
        valid = 2'b11;
        for (int c = 0; c < 14; c++) begin
            set_src(0, 8'(40 + c), 32'hC000 + 32'(c), 32'h4000 + 32'(c));
            set_src(1, 8'(60 + c), 32'hD000 + 32'(c), 32'h6000 + 32'(c));
            step();
            if (c == 6) begin
                check("full count0", 64'(bus1.fifo_count[2:0]), 64'd4);
                check("full ready0", 64'(bus1.src_ready[0]), 64'd0);
            end
            if (c == 7) check("full ready0 back", 64'(bus1.src_ready[0]), 64'd1);
        end

        // Stall for three cycles with a valid lane, then flush with entries buffered.
        valid = 2'b00;
        rdy   = 1'b0;
        repeat (3) begin
            step();
            check("stall en held", 64'(bus1.cdb_en), 64'd1);
        end
        rdy   = 1'b1;
        valid = 2'b11;
        clr   = 1'b1;
        step();
        check("flush en", 64'(bus1.cdb_en), 64'd0);
        check("flush count1", 64'(bus1.fifo_count), 64'd0);
        check("flush count2", 64'(bus2.fifo_count), 64'd0);
        clr   = 1'b0;
        valid = 2'b00;
        step();
        check("flush stays empty", 64'(bus1.cdb_en), 64'd0);

        // Sustained push and pop on src0 while src1 briefly competes.
        for (int c = 0; c < 12; c++) begin
            valid = {(c < 2), 1'b1};
            set_src(0, 8'(80 + c), 32'hE000 + 32'(c), 32'h8000 + 32'(c));
            set_src(1, 8'(100 + c), 32'hF000 + 32'(c), 32'h9000 + 32'(c));
            step();
        end
        valid = 2'b00;
        repeat (4) step();

        // Random traffic with stalls, flushes and one asynchronous reset.
        for (int i = 0; i < 1500; i++) begin
            valid = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
            rdy   = ($urandom_range(0, 9) != 0);
            clr   = ($urandom_range(0, 39) == 0);
            for (int s = 0; s < 2; s++) set_src(s, 8'($urandom), $urandom, $urandom);
            step();
            if (i == 700) begin
                #3 rst = 1'b1;
                step();
                rst = 1'b0;
            end
        end
        valid = 2'b00;
        rdy   = 1'b1;
        clr   = 1'b0;
        repeat (10) step();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
